// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM state encoding and default count width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   CNT_W_DEF   - default width of the period counter and reported result
//   pm_state_t  - measurement FSM states IDLE / ARM / MEASURE
package period_meter_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } pm_state_t;

endpackage

// File: rtl/pm_edge_detect.sv
// Rising-edge detector for the measured signal, with an optional input synchronizer.
// Latency: 1 clk from sig to o_rise (SYNC_STAGES+1 clk with PERIOD_METER_SYNC_EN defined).
// Backpressure: none; o_rise is a single-cycle pulse.
//
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset
//   i_sig   - measured square wave
//   o_rise  - registered one-cycle pulse for each rising edge of the (synchronized) input
// Build option: PERIOD_METER_SYNC_EN inserts SYNC_STAGES flops ahead of the edge register.
module pm_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_sig,
   output logic o_rise
);

   logic w_s;
   logic r_prev;
   logic r_rise;

`ifdef PERIOD_METER_SYNC_EN
   // Depth below two gives no metastability protection, so clamp it.
   localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_sig};
      end
   end

   assign w_s = r_sync[STAGES-1];
`else
   // Input is assumed clk-synchronous; it feeds the edge register directly.
   assign w_s = i_sig;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_prev <= w_s;
         r_rise <= w_s & ~r_prev;
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/period_meter.sv
// Measures clk cycles between consecutive rising edges of sig_in and reports each period.
// Latency: result registered 1 clk after the edge is detected (or after the counter saturates).
// Backpressure: single hold register; a result completing while the held one is stalled is
//               dropped and flagged on the next loaded result via res_ovr.
//
// Ports:
//   clk, rst    - rising-edge clock, asynchronous active-high reset
//   sig_in      - measured square wave
//   enable      - measurement enable; low returns the FSM to IDLE (held result is kept)
//   res_valid   - result held and available
//   res_ready   - consumer accepts the held result
//   res_period  - clk cycles between consecutive rising edges (all-ones when saturated)
//   res_sat     - no edge seen within 2^CNT_W-1 cycles
//   res_ovr     - at least one result was dropped before this one
// Build option: PERIOD_METER_SYNC_EN adds a SYNC_STAGES-deep input synchronizer.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             enable,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] res_period,
   output logic             res_sat,
   output logic             res_ovr
);

   localparam logic [CNT_W-1:0] C_MAX = '1;
   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

   logic             w_rise;
   logic             w_fire;
   logic             w_sat;
   logic [CNT_W-1:0] w_period;

   pm_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovr_flag;
   logic             r_valid;
   logic [CNT_W-1:0] r_period;
   logic             r_sat;
   logic             r_ovr;

   pm_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge (
      .clk    (clk),
      .rst    (rst),
      .i_sig  (sig_in),
      .o_rise (w_rise)
   );

   // A result completes on an edge while measuring, or when the count has
   // reached all-ones with no edge. An edge landing exactly on the all-ones
   // count is a genuine period and wins over saturation.
   always_comb begin
      w_fire   = 1'b0;
      w_sat    = 1'b0;
      w_period = r_cnt;
      if (enable && (r_state == MEASURE)) begin
         if (w_rise) begin
            w_fire = 1'b1;
         end else if (r_cnt == C_MAX) begin
            w_fire = 1'b1;
            w_sat  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else if (!enable) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state <= ARM;
               r_cnt   <= '0;
            end
            ARM: begin
               // First edge only opens the measurement window.
               if (w_rise) begin
                  r_state <= MEASURE;
                  r_cnt   <= C_ONE;
               end
            end
            MEASURE: begin
               if (w_rise) begin
                  r_cnt <= C_ONE;
               end else if (r_cnt == C_MAX) begin
                  r_state <= ARM;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Hold register: loads when empty or being drained this cycle, otherwise
   // the new result is lost and remembered in the sticky overrun flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_period   <= '0;
         r_sat      <= 1'b0;
         r_ovr      <= 1'b0;
         r_ovr_flag <= 1'b0;
      end else if (w_fire && (!r_valid || res_ready)) begin
         r_valid    <= 1'b1;
         r_period   <= w_period;
         r_sat      <= w_sat;
         r_ovr      <= r_ovr_flag;
         r_ovr_flag <= 1'b0;
      end else begin
         if (w_fire) begin
            r_ovr_flag <= 1'b1;
         end
         if (r_valid && res_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign res_valid  = r_valid;
   assign res_period = r_period;
   assign res_sat    = r_sat;
   assign res_ovr    = r_ovr;

endmodule

// File: tb/tb_period_meter.sv
// Randomized scoreboard bench for period_meter: a rise-time model predicts results.
// Latency: results expected LAT clk after each applied rising edge of sig_in.
// Backpressure: res_ready driven constant, held off, or random; drops tracked by the model.
module tb_period_meter;

   localparam int CNT_W = 4;
   localparam int MAX   = (1 << CNT_W) - 1;
`ifdef PERIOD_METER_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             sig_in = 1'b0;
   logic             enable = 1'b0;
   logic             res_ready = 1'b0;
   logic             res_valid;
   logic [CNT_W-1:0] res_period;
   logic             res_sat;
   logic             res_ovr;

   period_meter #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sig_in     (sig_in),
      .enable     (enable),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_period (res_period),
      .res_sat    (res_sat),
      .res_ovr    (res_ovr)
   );

   always #5 clk = ~clk;

   typedef struct {
      int t;
      int p;
      bit sat;
   } evt_t;

   typedef struct {
      int p;
      bit sat;
      bit ovr;
   } res_t;

   evt_t sched[$];   // results about to complete, by completion cycle
   res_t exp_q[$];   // results that made it into the output, in order

   int cyc       = 0;
   int last_rise = 0;
   bit armed     = 0;
   bit en_model  = 0;
   bit m_valid   = 0;
   bit m_flag    = 0;
   int rdy_mode  = 0;   // 0: low, 1: high, 2: random
   int rdy_hold  = 0;
   int checks    = 0;
   int errors    = 0;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // A rise closes the running period (if armed) and starts the next one.
   task automatic note_rise(input int n);
      evt_t e;
      if (en_model) begin
         if (armed) begin
            e.t = n + LAT;
            e.p = n - last_rise;
            e.sat = 1'b0;
            sched.push_back(e);
         end
         last_rise = n;
         armed = 1'b1;
      end
   endtask

   task automatic model_reset();
      sched.delete();
      exp_q.delete();
      armed = 1'b0;
      m_valid = 1'b0;
      m_flag = 1'b0;
   endtask

   task automatic model_step();
      evt_t e;
      res_t r;
      bit fired;
      cyc++;
      if (!rst) begin
         // No rise within MAX cycles: a saturated result, then re-arm.
         if (armed && en_model && (cyc == last_rise + MAX + 1)) begin
            e.t = cyc + LAT - 1;
            e.p = MAX;
            e.sat = 1'b1;
            sched.push_back(e);
            armed = 1'b0;
         end
         fired = 1'b0;
         while (sched.size() > 0 && sched[0].t == cyc) begin
            e = sched.pop_front();
            fired = 1'b1;
            if (!m_valid || res_ready) begin
               r.p = e.p;
               r.sat = e.sat;
               r.ovr = m_flag;
               exp_q.push_back(r);
               m_valid = 1'b1;
               m_flag = 1'b0;
            end else begin
               m_flag = 1'b1;
            end
         end
         if (!fired && m_valid && res_ready) m_valid = 1'b0;
      end
   endtask

   task automatic mon_step();
      chk("res_valid", int'(res_valid), int'(m_valid));
      if (res_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got period %0d with nothing expected (cycle %0d)",
                     res_period, cyc);
         end else begin
            chk("res_period", int'(res_period), exp_q[0].p);
            chk("res_sat", int'(res_sat), int'(exp_q[0].sat));
            chk("res_ovr", int'(res_ovr), int'(exp_q[0].ovr));
            if (res_ready) void'(exp_q.pop_front());
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (!rst) mon_step();
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_hold > 0) begin
         res_ready = 1'b0;
         rdy_hold--;
      end else begin
         case (rdy_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            default: res_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic tick(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic drive_period(input int p);
      sig_in = 1'b1;
      note_rise(cyc);
      tick(p / 2);
      sig_in = 1'b0;
      tick(p - p / 2);
   endtask

   task automatic set_enable(input bit en);
      enable = en;
      en_model = en;
      armed = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_valid"}, int'(res_valid), 0);
      chk({tag, "_period"}, int'(res_period), 0);
      chk({tag, "_sat"}, int'(res_sat), 0);
      chk({tag, "_ovr"}, int'(res_ovr), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      tick(3);
      check_outputs_zero("reset");
      rst = 1'b0;
      tick(1);

      // Toggle-rate input: every result is period 2.
      rdy_mode = 1;
      set_enable(1'b1);
      tick(2);
      repeat (20) drive_period(2);
      sig_in = 1'b0;
      tick(8);

      // Consumer stalled 35 cycles against period-10 input: drops and ovr.
      rdy_hold = 35;
      repeat (8) drive_period(10);

      // Input stuck low: saturated result, then the next edge only arms.
      sig_in = 1'b0;
      tick(30);
      repeat (3) drive_period(5);

      // Periods right at and just past the saturation limit.
      repeat (3) drive_period(MAX);
      repeat (2) drive_period(MAX + 1);
      repeat (2) drive_period(3);

      // Reset in the middle of a measurement with a result held.
      rdy_mode = 0;
      repeat (3) drive_period(6);
      sig_in = 1'b1;
      note_rise(cyc);
      tick(6);
      sig_in = 1'b0;
      tick(2);
      #2;
      rst = 1'b1;
      #1;
      check_outputs_zero("midreset");
      model_reset();
      tick(2);
      rst = 1'b0;
      rdy_mode = 1;
      tick(3);
      repeat (4) drive_period(7);

      // Disable with a result held: it survives, then no results until re-armed.
      rdy_mode = 0;
      repeat (3) drive_period(8);
      sig_in = 1'b0;
      tick(6);
      set_enable(1'b0);
      tick(1);
      repeat (5) drive_period(4);
      rdy_mode = 1;
      tick(3);
      repeat (3) drive_period(5);
      sig_in = 1'b0;
      tick(6);
      set_enable(1'b1);
      tick(2);
      repeat (4) drive_period(5);

      // Random periods across the full range with random backpressure.
      rdy_mode = 2;
      repeat (150) drive_period(int'($urandom_range(2, MAX + 4)));

      // Drain.
      sig_in = 1'b0;
      tick(MAX + 10);
      rdy_mode = 1;
      tick(10);
      chk("drain_expected_left", exp_q.size(), 0);
      chk("drain_pending_left", sched.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
